bch_enc_ctrl: RTL and testbench
===============================

// Module: bch_enc_ctrl
// PURPOSE
//  Sequencer for the serial BCH(15,7) encoder (`encoder`). Accepts a parallel 7-bit message
//  on a valid/ready handshake, clears the encoder, shifts the message in MSB first, waits
//  for o_done, and presents the systematic 15-bit codeword {msg, parity} on a valid/ready output.
//  Sits between the message source and the codeword sink. Owns the only encoder instance.
// PARAMETERS
//  DONE_TIMEOUT  16  max cycles in WAIT before abort (used only with BCH_ENC_CTRL_TIMEOUT_EN)
// PORTS
//  i_clk          in   1   clock; all logic on rising edge
//  i_rst          in   1   synchronous, active-high reset
//  i_msg          in   7   message word, bit 6 transmitted first
//  i_msg_valid    in   1   message valid
//  o_msg_ready    out  1   controller can accept a message (high only in IDLE)
//  o_cw           out  15  codeword {msg[6:0], parity[7:0]}
//  o_cw_valid     out  1   codeword valid; held until i_cw_ready
//  i_cw_ready     in   1   sink accepts codeword
//  o_busy         out  1   state != IDLE
//  o_err          out  1   one-cycle pulse on encoder timeout (constant 0 without macro)
// BEHAVIOUR
//  - Reset: state=IDLE; o_msg_ready=0 in reset cycle, 1 first cycle after; o_cw=0,
//    o_cw_valid=0, o_busy=0, o_err=0; encoder held in reset (i_rst_n=~i_rst), i_dv=0, i_m=0.
//  - FSM: IDLE -> CLR -> SHIFT -> WAIT -> OUT -> IDLE.
//    IDLE : o_msg_ready=1; on i_msg_valid&&o_msg_ready latch i_msg into msg_q, go CLR.
//    CLR  : encoder i_rst_n=0 for exactly 1 cycle; bit counter=0; go SHIFT.
//    SHIFT: i_dv=1, i_m=msg_q[6-cnt]; cnt increments each cycle; after cnt==6 go WAIT
//           (exactly 7 i_dv cycles per word).
//    WAIT : i_dv=0; on encoder o_done capture o_parity -> o_cw={msg_q,o_parity}, go OUT.
//    OUT  : o_cw_valid=1; o_cw stable; on i_cw_ready go IDLE (o_cw_valid low next cycle).
//  - Min latency accept->o_cw_valid = 1 (CLR) + 7 (SHIFT) + encoder done latency + 1.
//  - No back-to-back accept: new message accepted only after codeword handshake completes.
//  - o_done outside WAIT is ignored. i_msg_valid outside IDLE is not consumed.
//  - i_rst asserted in any state: next cycle as reset values; in-flight word discarded,
//    no partial codeword ever asserted.
//  - i_cw_ready held low: stays in OUT indefinitely, o_cw unchanged.
// CONFIGURATION
//  BCH_ENC_CTRL_TIMEOUT_EN defined: WAIT counter counts cycles without o_done; at
//    DONE_TIMEOUT, o_err=1 for one cycle, word dropped, -> IDLE (encoder cleared on next CLR).
//  Undefined: no counter; WAIT lasts until o_done; o_err tied 0.
// STRUCTURE
//  Package bch_pkg: localparams BCH_K=7, BCH_N=15, BCH_P=8; typedef enum of FSM states
//    {ST_IDLE, ST_CLR, ST_SHIFT, ST_WAIT, ST_OUT}.
//  Single sub-module: existing `encoder` instance (i_clk, i_rst_n, i_m, i_dv, o_parity, o_done).
//  Encoder reset = ~(i_rst | state==ST_CLR). No other sub-modules.
// TESTING
//  1. Reset 3 cycles, release -> o_msg_ready=1, o_cw_valid=0, o_busy=0, o_err=0.
//  2. i_msg=7'h40, i_cw_ready=1 -> i_dv high exactly 7 cycles, i_m=1,0,0,0,0,0,0; o_cw=15'h40E8.
//  3. i_msg=7'h01 -> o_cw=15'h01D1; i_msg=7'h00 -> o_cw=15'h0000; i_msg=7'h41 -> o_cw=15'h4139.
//  4. i_cw_ready low 10 cycles after o_cw_valid -> o_cw stable, o_msg_ready=0; raise ready
//     -> o_cw_valid drops next cycle, o_msg_ready=1.
//  5. i_rst pulsed mid-SHIFT (after 3 bits) -> outputs at reset values, no o_cw_valid;
//     next word 7'h40 -> o_cw=15'h40E8.
//  6. With BCH_ENC_CTRL_TIMEOUT_EN, o_done forced low -> o_err one-cycle pulse DONE_TIMEOUT
//     cycles into WAIT, o_cw_valid never set, o_msg_ready=1 next cycle.

Source files
------------

// File: rtl/bch_pkg.sv
// Shared constants and FSM state encoding for the BCH(15,7) encoder sequencer.
package bch_pkg;

  localparam int BCH_K = 7;
  localparam int BCH_N = 15;
  localparam int BCH_P = 8;

  // g(x) = x^8 + x^7 + x^6 + x^4 + 1
  localparam logic [BCH_P:0] BCH_GEN = 9'h1D1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SHIFT,
    ST_WAIT,
    ST_OUT
  } state_t;

endpackage

// File: rtl/encoder.sv
// Serial systematic BCH(15,7) parity LFSR; takes K bits MSB first, raises o_done once all are in.
module encoder
  import bch_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_m,
  input  logic             i_dv,
  output logic [BCH_P-1:0] o_parity,
  output logic             o_done
);

  logic [BCH_P-1:0] par_reg;
  logic [2:0]       cnt_reg;
  logic             done_reg;
  logic             fb;

  assign fb = i_m ^ par_reg[BCH_P-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      par_reg  <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else if (i_dv && !done_reg) begin
      // Division remainder of m(x)*x^8 by g(x), one message bit per cycle
      par_reg <= {par_reg[BCH_P-2:0], 1'b0} ^ (fb ? BCH_GEN[BCH_P-1:0] : '0);
      cnt_reg <= cnt_reg + 3'd1;
      if (cnt_reg == 3'(BCH_K - 1)) begin
        done_reg <= 1'b1;
      end
    end
  end

  assign o_parity = par_reg;
  assign o_done   = done_reg;

endmodule

// File: rtl/bch_enc_ctrl.sv
// Handshake sequencer around the serial BCH(15,7) encoder.
// Optional WAIT-state watchdog enabled by defining BCH_ENC_CTRL_TIMEOUT_EN.
module bch_enc_ctrl
  import bch_pkg::*;
#(
  parameter int DONE_TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [BCH_K-1:0] i_msg,
  input  logic             i_msg_valid,
  output logic             o_msg_ready,
  output logic [BCH_N-1:0] o_cw,
  output logic             o_cw_valid,
  input  logic             i_cw_ready,
  output logic             o_busy,
  output logic             o_err
);

  if (DONE_TIMEOUT < 1) begin : g_bad_timeout
    $error("DONE_TIMEOUT must be at least 1");
  end

  state_t           state_reg, state_next;
  logic [BCH_K-1:0] msg_reg;
  logic [2:0]       cnt_reg;
  logic [BCH_N-1:0] cw_reg;
  logic             ready_reg;
  logic             err_reg;
  logic             timeout;

  logic             enc_rst_n;
  logic             enc_dv;
  logic             enc_m;
  logic [BCH_P-1:0] enc_parity;
  logic             enc_done;

  // Encoder is cleared for the single CLR cycle before every word
  assign enc_rst_n = ~(i_rst | (state_reg == ST_CLR));
  assign enc_dv    = (state_reg == ST_SHIFT) && !i_rst;
  assign enc_m     = enc_dv ? msg_reg[3'(BCH_K - 1) - cnt_reg] : 1'b0;

  encoder u_enc (
    .i_clk    (i_clk),
    .i_rst_n  (enc_rst_n),
    .i_m      (enc_m),
    .i_dv     (enc_dv),
    .o_parity (enc_parity),
    .o_done   (enc_done)
  );

`ifdef BCH_ENC_CTRL_TIMEOUT_EN
  localparam int WAIT_W = $clog2(DONE_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst || state_reg != ST_WAIT) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  assign timeout = (state_reg == ST_WAIT) && !enc_done &&
                   (wait_cnt_reg == WAIT_W'(DONE_TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (i_msg_valid && ready_reg) state_next = ST_CLR;
      ST_CLR:   state_next = ST_SHIFT;
      ST_SHIFT: if (cnt_reg == 3'(BCH_K - 1)) state_next = ST_WAIT;
      ST_WAIT: begin
        if (enc_done) state_next = ST_OUT;
        else if (timeout) state_next = ST_IDLE;
      end
      ST_OUT:   if (i_cw_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      msg_reg   <= '0;
      cnt_reg   <= '0;
      cw_reg    <= '0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Ready is registered so it stays low during the reset cycle itself
      ready_reg <= (state_next == ST_IDLE);
      err_reg   <= timeout;
      if (state_reg == ST_IDLE && i_msg_valid && ready_reg) begin
        msg_reg <= i_msg;
      end
      if (state_reg == ST_CLR) begin
        cnt_reg <= '0;
      end else if (state_reg == ST_SHIFT) begin
        cnt_reg <= cnt_reg + 3'd1;
      end
      if (state_reg == ST_WAIT && enc_done) begin
        cw_reg <= {msg_reg, enc_parity};
      end
    end
  end

  assign o_msg_ready = ready_reg;
  assign o_cw        = cw_reg;
  assign o_cw_valid  = (state_reg == ST_OUT);
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_err       = err_reg;

endmodule

// File: tb/tb_bch_enc_ctrl.sv
// Self-checking bench for bch_enc_ctrl: directed vectors plus random words against a polynomial-division model.
module tb_bch_enc_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [6:0]  i_msg = '0;
  logic        i_msg_valid = 1'b0;
  logic        o_msg_ready;
  logic [14:0] o_cw;
  logic        o_cw_valid;
  logic        i_cw_ready = 1'b0;
  logic        o_busy;
  logic        o_err;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  bch_enc_ctrl #(.DONE_TIMEOUT(16)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_msg       (i_msg),
    .i_msg_valid (i_msg_valid),
    .o_msg_ready (o_msg_ready),
    .o_cw        (o_cw),
    .o_cw_valid  (o_cw_valid),
    .i_cw_ready  (i_cw_ready),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Systematic codeword by long division of m(x)*x^8 by g(x)
  function automatic logic [14:0] ref_cw(input logic [6:0] m);
    int rem;
    rem = int'(m) << 8;
    for (int b = 14; b >= 8; b--) begin
      if (rem[b]) rem = rem ^ (32'h1D1 << (b - 8));
    end
    return {m, rem[7:0]};
  endfunction

  task automatic send(input logic [6:0] m, input int stall);
    int          guard;
    int          dv_cnt;
    logic [6:0]  bits;
    logic [14:0] exp;
    logic [14:0] held;
    exp = ref_cw(m);
    i_cw_ready = (stall == 0);
    guard = 0;
    while (!o_msg_ready && guard < 50) begin
      @(negedge i_clk);
      guard++;
    end
    check("msg_ready_idle", {31'd0, o_msg_ready}, 32'd1);
    i_msg = m;
    i_msg_valid = 1'b1;
    @(negedge i_clk);
    i_msg_valid = 1'b0;
    i_msg = 7'($urandom);
    dv_cnt = 0;
    bits = '0;
    guard = 0;
    while (!o_cw_valid && guard < 40) begin
      if (dut.enc_dv) begin
        bits = {bits[5:0], dut.enc_m};
        dv_cnt++;
      end
      @(negedge i_clk);
      guard++;
    end
    check("cw_valid_seen", {31'd0, o_cw_valid}, 32'd1);
    check("dv_cycles", dv_cnt, 32'd7);
    check("serial_bits", {25'd0, bits}, {25'd0, m});
    check("codeword", {17'd0, o_cw}, {17'd0, exp});
    check("ready_low_busy", {30'd0, o_msg_ready, o_busy}, 32'd1);
    held = o_cw;
    if (stall > 0) begin
      repeat (stall) @(negedge i_clk);
      check("stall_cw_stable", {17'd0, o_cw}, {17'd0, held});
      check("stall_valid_ready", {30'd0, o_cw_valid, o_msg_ready}, 32'd2);
      i_cw_ready = 1'b1;
    end
    @(negedge i_clk);
    check("post_hs_valid_ready", {30'd0, o_cw_valid, o_msg_ready}, 32'd1);
    $display("[TB] msg=%02h stall=%0d cw=%04h exp=%04h", m, stall, held, exp);
  endtask

  initial begin
    int guard;
    int dv_cnt;
    int vcnt;
    // Reset held for three cycles
    repeat (3) @(negedge i_clk);
    check("rst_outputs", {13'd0, o_msg_ready, o_cw_valid, o_busy, o_err, o_cw}, 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("post_rst_ready", {28'd0, o_msg_ready, o_cw_valid, o_busy, o_err}, 32'd8);
    check("post_rst_cw", {17'd0, o_cw}, 32'd0);

    // Directed vectors
    send(7'h40, 0);
    check("vec_40", {17'd0, dut.o_cw}, 32'h40E8);
    send(7'h01, 0);
    check("vec_01", {17'd0, o_cw}, 32'h01D1);
    send(7'h00, 0);
    check("vec_00", {17'd0, o_cw}, 32'h0000);
    send(7'h41, 0);
    check("vec_41", {17'd0, o_cw}, 32'h4139);
    send(7'h2A, 10);

    // Reset in the middle of SHIFT
    i_msg = 7'h55;
    i_msg_valid = 1'b1;
    @(negedge i_clk);
    i_msg_valid = 1'b0;
    dv_cnt = 0;
    guard = 0;
    while (dv_cnt < 3 && guard < 20) begin
      @(negedge i_clk);
      if (dut.enc_dv) dv_cnt++;
      guard++;
    end
    check("mid_shift_reached", dv_cnt, 32'd3);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("mid_rst_outputs", {13'd0, o_msg_ready, o_cw_valid, o_busy, o_err, o_cw}, 32'd0);
    i_rst = 1'b0;
    vcnt = 0;
    repeat (15) begin
      @(negedge i_clk);
      if (o_cw_valid) vcnt++;
    end
    check("no_partial_cw", vcnt, 32'd0);
    check("mid_rst_ready", {31'd0, o_msg_ready}, 32'd1);
    send(7'h40, 0);
    check("after_rst_40", {17'd0, o_cw}, 32'h40E8);

    // Random words with random sink stalls
    for (int i = 0; i < 12; i++) begin
      send(7'($urandom), int'($urandom_range(0, 4)));
    end

`ifdef BCH_ENC_CTRL_TIMEOUT_EN
    force dut.enc_done = 1'b0;
    i_msg = 7'h33;
    i_msg_valid = 1'b1;
    @(negedge i_clk);
    i_msg_valid = 1'b0;
    guard = 0;
    vcnt = 0;
    while (!o_err && guard < 60) begin
      @(negedge i_clk);
      if (o_cw_valid) vcnt++;
      guard++;
    end
    check("timeout_err", {31'd0, o_err}, 32'd1);
    check("timeout_no_cw", vcnt, 32'd0);
    check("timeout_ready", {31'd0, o_msg_ready}, 32'd1);
    @(negedge i_clk);
    check("timeout_err_pulse", {31'd0, o_err}, 32'd0);
    release dut.enc_done;
    send(7'h01, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
